// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared state, flag and width constants for the sequencer.
// Flag vectors are always laid out as {N, Z, C, V}.
package alu_seq_pkg;

  localparam int DATA_W = 8;
  localparam int OP_W   = 3;
  localparam int CANT_W = 2;
  localparam int FLAG_W = 4;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam logic [OP_W-1:0] OP_ADD = 3'd0;
  localparam logic [OP_W-1:0] OP_SUB = 3'd1;
  localparam logic [OP_W-1:0] OP_AND = 3'd2;
  localparam logic [OP_W-1:0] OP_OR  = 3'd3;
  localparam logic [OP_W-1:0] OP_XOR = 3'd4;
  localparam logic [OP_W-1:0] OP_SHL = 3'd5;
  localparam logic [OP_W-1:0] OP_SHR = 3'd6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/ALU_S_Flags.sv
// ALU_S_Flags: 8-bit ALU with N/Z/C/V flags.
// Sub carry is "no borrow"; code 7 passes A through.
module ALU_S_Flags
  import alu_seq_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [OP_W-1:0]   alu_control,
  input  logic [CANT_W-1:0] cantidad,
  output logic [DATA_W-1:0] resultado,
  output logic [FLAG_W-1:0] flags
);

  localparam int MSB = DATA_W - 1;

  logic [DATA_W:0] sum;
  logic [DATA_W:0] dif;
  logic            carry;
  logic            ovf;

  assign sum = {1'b0, a} + {1'b0, b};
  assign dif = {1'b0, a} + {1'b0, ~b}
             + {{DATA_W{1'b0}}, 1'b1};

  // Operation select plus flag generation from the result
  always_comb begin
    resultado = '0;
    carry     = 1'b0;
    ovf       = 1'b0;
    case (alu_control)
      OP_ADD: begin
        resultado = sum[MSB:0];
        carry     = sum[DATA_W];
        ovf       = (a[MSB] == b[MSB])
                 && (sum[MSB] != a[MSB]);
      end
      OP_SUB: begin
        resultado = dif[MSB:0];
        carry     = dif[DATA_W];
        ovf       = (a[MSB] != b[MSB])
                 && (dif[MSB] != a[MSB]);
      end
      OP_AND:  resultado = a & b;
      OP_OR:   resultado = a | b;
      OP_XOR:  resultado = a ^ b;
      OP_SHL:  resultado = a << cantidad;
      OP_SHR:  resultado = a >> cantidad;
      default: resultado = a;
    endcase
    flags         = '0;
    flags[FLAG_N] = resultado[MSB];
    flags[FLAG_Z] = ~|resultado;
    flags[FLAG_C] = carry;
    flags[FLAG_V] = ovf;
  end

endmodule

// File: rtl/alu_req_sequencer.sv
// alu_req_sequencer: two-requester front end for ALU_S_Flags.
// Define ALU_SEQ_RR_EN for round-robin ties; else req0 wins.
module alu_req_sequencer
  import alu_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic              req1_valid,
  output logic              req0_ready,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [OP_W-1:0]   req0_op,
  input  logic [OP_W-1:0]   req1_op,
  input  logic [CANT_W-1:0] req0_cant,
  input  logic [CANT_W-1:0] req1_cant,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_result,
  output logic [FLAG_W-1:0] rsp_flags,
  output logic [FLAG_W-1:0] flags_q,
  output logic              busy
);

  state_t              state;
  logic [DATA_W-1:0]   a_q;
  logic [DATA_W-1:0]   b_q;
  logic [OP_W-1:0]     op_q;
  logic [CANT_W-1:0]   cant_q;
  logic                id_q;
  logic [DATA_W-1:0]   alu_res;
  logic [FLAG_W-1:0]   alu_flags;
  logic                grant_id;
  logic                take;
`ifdef ALU_SEQ_RR_EN
  logic                last_grant;
`endif

  // Pick the winner among pending requesters
  always_comb begin
    grant_id = 1'b0;
    if (req1_valid && !req0_valid)
      grant_id = 1'b1;
`ifdef ALU_SEQ_RR_EN
    else if (req0_valid && req1_valid)
      grant_id = ~last_grant;
`endif
  end

  // Gated by rst_n so an accept never coincides with reset
  assign take = rst_n && (state == IDLE)
             && (req0_valid || req1_valid);
  assign req0_ready = take && !grant_id;
  assign req1_ready = take && grant_id;

  ALU_S_Flags u_alu (
    .a           (a_q),
    .b           (b_q),
    .alu_control (op_q),
    .cantidad    (cant_q),
    .resultado   (alu_res),
    .flags       (alu_flags)
  );

  // Sequencer FSM: accept, execute one cycle, hold response
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      cant_q     <= '0;
      id_q       <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_flags  <= '0;
      flags_q    <= '0;
      busy       <= 1'b0;
`ifdef ALU_SEQ_RR_EN
      last_grant <= 1'b1;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (take) begin
            a_q    <= grant_id ? req1_a : req0_a;
            b_q    <= grant_id ? req1_b : req0_b;
            op_q   <= grant_id ? req1_op : req0_op;
            cant_q <= grant_id ? req1_cant
                               : req0_cant;
            id_q   <= grant_id;
            busy   <= 1'b1;
            state  <= EXEC;
`ifdef ALU_SEQ_RR_EN
            last_grant <= grant_id;
`endif
          end
        end
        EXEC: begin
          rsp_result <= alu_res;
          rsp_flags  <= alu_flags;
          flags_q    <= alu_flags;
          rsp_id     <= id_q;
          rsp_valid  <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_req_sequencer.sv
// tb_alu_req_sequencer: vector table, corner sequences, random run.
// Arbitration expectations follow ALU_SEQ_RR_EN.
module tb_alu_req_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0_valid = 1'b0;
  logic       req1_valid = 1'b0;
  logic       req0_ready;
  logic       req1_ready;
  logic [7:0] req0_a = '0;
  logic [7:0] req0_b = '0;
  logic [7:0] req1_a = '0;
  logic [7:0] req1_b = '0;
  logic [2:0] req0_op = '0;
  logic [2:0] req1_op = '0;
  logic [1:0] req0_cant = '0;
  logic [1:0] req1_cant = '0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic       rsp_id;
  logic [7:0] rsp_result;
  logic [3:0] rsp_flags;
  logic [3:0] flags_q;
  logic       busy;

  int checks = 0;
  int errors = 0;

  alu_req_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req1_valid (req1_valid),
    .req0_ready (req0_ready),
    .req1_ready (req1_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req0_op    (req0_op),
    .req1_op    (req1_op),
    .req0_cant  (req0_cant),
    .req1_cant  (req1_cant),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_flags  (rsp_flags),
    .flags_q    (flags_q),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       id;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] cant;
    logic [7:0] res;
    logic [3:0] fl;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h",
               nm, act, exp);
    end
  endtask

  // Reference ALU from plain integer arithmetic: {N,Z,C,V,res}
  function automatic logic [11:0] ref_alu(
      input logic [2:0] op, input logic [7:0] a,
      input logic [7:0] b, input logic [1:0] cant);
    int ua, ub, sa, sb, r, s;
    logic c, v;
    logic [7:0] res;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    c = 1'b0;
    v = 1'b0;
    r = ua;
    case (op)
      3'd0: begin
        r = ua + ub;
        c = (r > 255);
        s = sa + sb;
        v = (s > 127) || (s < -128);
      end
      3'd1: begin
        r = ua - ub;
        c = (ua >= ub);
        s = sa - sb;
        v = (s > 127) || (s < -128);
      end
      3'd2: r = ua & ub;
      3'd3: r = ua | ub;
      3'd4: r = ua ^ ub;
      3'd5: r = ua * (1 << cant);
      3'd6: r = ua / (1 << cant);
      default: r = ua;
    endcase
    res = r[7:0];
    return {res[7], (res == 8'h00), c, v, res};
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic drive(input logic id, input logic [2:0] op,
                       input logic [7:0] a, input logic [7:0] b,
                       input logic [1:0] cant);
    if (id) begin
      req1_op = op; req1_a = a;
      req1_b = b; req1_cant = cant;
    end else begin
      req0_op = op; req0_a = a;
      req0_b = b; req0_cant = cant;
    end
  endtask

  // One operation from one requester with latency check
  task automatic do_op(input vec_t t);
    int n;
    drive(t.id, t.op, t.a, t.b, t.cant);
    req0_valid = !t.id;
    req1_valid = t.id;
    rsp_ready = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(req0_ready || req1_ready) && n < 10);
    chk("op_ready", t.id ? req1_ready : req0_ready, 1);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid && n < 10);
    chk("op_latency", n, 2);
    chk("op_id", rsp_id, t.id);
    chk("op_result", rsp_result, t.res);
    chk("op_flags", rsp_flags, t.fl);
    chk("op_flags_q", flags_q, t.fl);
    @(posedge clk);
    #1;
  endtask

  logic        exp_g[4];
  logic [12:0] sb_q[$];

  initial begin
    int n;
    int bad;
    logic [3:0] saw;
    logic inflight;
    int lat;
    logic last_g;
    logic any, g, acc;
    logic [11:0] r;

    tbl[0]  = '{1'b0, 3'd0, 8'h7F, 8'h01, 2'd0, 8'h80, 4'b1001};
    tbl[1]  = '{1'b1, 3'd0, 8'hFF, 8'h01, 2'd0, 8'h00, 4'b0110};
    tbl[2]  = '{1'b0, 3'd1, 8'h05, 8'h05, 2'd0, 8'h00, 4'b0110};
    tbl[3]  = '{1'b1, 3'd1, 8'h00, 8'h01, 2'd0, 8'hFF, 4'b1000};
    tbl[4]  = '{1'b0, 3'd1, 8'h80, 8'h01, 2'd0, 8'h7F, 4'b0011};
    tbl[5]  = '{1'b1, 3'd2, 8'hF0, 8'h3C, 2'd0, 8'h30, 4'b0000};
    tbl[6]  = '{1'b0, 3'd3, 8'h00, 8'h00, 2'd0, 8'h00, 4'b0100};
    tbl[7]  = '{1'b1, 3'd4, 8'hAA, 8'hFF, 2'd0, 8'h55, 4'b0000};
    tbl[8]  = '{1'b0, 3'd5, 8'h81, 8'h00, 2'd1, 8'h02, 4'b0000};
    tbl[9]  = '{1'b1, 3'd6, 8'h81, 8'h00, 2'd3, 8'h10, 4'b0000};
    tbl[10] = '{1'b0, 3'd7, 8'h9C, 8'h11, 2'd2, 8'h9C, 4'b1000};

    // Reset values, with both requesters asking
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_req0_ready", req0_ready, 0);
    chk("rst_req1_ready", req1_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_result", rsp_result, 0);
    chk("rst_rsp_flags", rsp_flags, 0);
    chk("rst_flags_q", flags_q, 0);
    chk("rst_busy", busy, 0);
    do_reset();

    for (int i = 0; i < 11; i++) do_op(tbl[i]);

    // Both requesters valid for four operations
    do_reset();
`ifdef ALU_SEQ_RR_EN
    exp_g = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_g = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
    drive(1'b0, 3'd0, 8'd1, 8'd2, 2'd0);
    drive(1'b1, 3'd0, 8'd10, 8'd20, 2'd0);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!(req0_ready || req1_ready) && n < 10);
      chk("arb_accept_seen", n < 10, 1);
      chk("arb_grant", req1_ready, exp_g[k]);
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!rsp_valid && n < 10);
      chk("arb_rsp_id", rsp_id, exp_g[k]);
      chk("arb_result", rsp_result,
          exp_g[k] ? 30 : 3);
    end
    @(posedge clk);
    #1;

    // Backpressure in RESP
    do_reset();
    drive(1'b0, 3'd0, 8'h7F, 8'h01, 2'd0);
    drive(1'b1, 3'd0, 8'h03, 8'h04, 2'd0);
    req0_valid = 1'b1;
    @(negedge clk);
    chk("bp_accept", req0_ready, 1);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid && n < 10);
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_result !== 8'h80
          || rsp_flags !== 4'b1001 || rsp_id !== 1'b0
          || req0_ready !== 1'b0 || req1_ready !== 1'b0
          || busy !== 1'b1)
        bad++;
    end
    chk("bp_hold_cycles_bad", bad, 0);
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_no_early_ready", req1_ready, 0);
    @(negedge clk);
    chk("bp_accept_after_hs", req1_ready, 1);
    @(posedge clk);
    #1 req1_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid && n < 10);
    chk("bp_second_result", rsp_result, 8'h07);
    chk("bp_second_id", rsp_id, 1);
    @(posedge clk);
    #1;

    // Reset in EXEC discards the operation
    do_op(tbl[0]);
    drive(1'b0, 3'd0, 8'hFF, 8'h01, 2'd0);
    req0_valid = 1'b1;
    @(negedge clk);
    chk("rx_accept", req0_ready, 1);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("rx_in_exec", busy, 1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rx_busy", busy, 0);
    chk("rx_rsp_valid", rsp_valid, 0);
    chk("rx_flags_q", flags_q, 0);
    saw = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (rsp_valid) saw++;
    end
    chk("rx_no_response", saw, 0);

    // Random traffic against a transaction-level model
    do_reset();
    inflight = 1'b0;
    lat = 0;
    last_g = 1'b1;
    for (int it = 0; it < 400; it++) begin
      req0_valid = ($urandom_range(0, 2) != 0);
      req1_valid = ($urandom_range(0, 2) != 0);
      drive(1'b0, 3'($urandom_range(0, 7)),
            8'($urandom), 8'($urandom),
            2'($urandom_range(0, 3)));
      drive(1'b1, 3'($urandom_range(0, 7)),
            8'($urandom), 8'($urandom),
            2'($urandom_range(0, 3)));
      rsp_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      any = req0_valid || req1_valid;
      acc = !inflight && any;
      if (req0_valid && req1_valid) begin
`ifdef ALU_SEQ_RR_EN
        g = ~last_g;
`else
        g = 1'b0;
`endif
      end else begin
        g = req1_valid;
      end
      chk("rnd_busy", busy, inflight);
      chk("rnd_rsp_valid", rsp_valid,
          inflight && lat >= 2);
      chk("rnd_ready", {req1_ready, req0_ready},
          {acc && g, acc && !g});
      if (rsp_valid && inflight && lat >= 2
          && sb_q.size() > 0) begin
        chk("rnd_id", rsp_id, sb_q[0][12]);
        chk("rnd_flags", rsp_flags, sb_q[0][11:8]);
        chk("rnd_flags_q", flags_q, sb_q[0][11:8]);
        chk("rnd_result", rsp_result, sb_q[0][7:0]);
        if (rsp_ready) begin
          void'(sb_q.pop_front());
          inflight = 1'b0;
        end
      end
      if (inflight) lat++;
      if (acc) begin
        r = g ? ref_alu(req1_op, req1_a, req1_b, req1_cant)
              : ref_alu(req0_op, req0_a, req0_b, req0_cant);
        sb_q.push_back({g, r});
        inflight = 1'b1;
        lat = 1;
        last_g = g;
      end
      @(posedge clk);
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
